// File: rtl/keccak_pkg.sv
// keccak_pkg: shared Keccak/SHAKE widths, mode encodings, dump depths and byte-order helper
package keccak_pkg;
  localparam int w = 64;
  localparam int w_byte_width = 8;
  localparam int w_byte_size = w / w_byte_width;
  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;
  localparam logic [1:0] SHAKE128_MODE_VEC = 2'b10;
  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b11;
  localparam int DUMP_DEPTH_SHAKE128 = RATE_SHAKE128 / w;
  localparam int DUMP_DEPTH_SHAKE256 = RATE_SHAKE256 / w;
  typedef enum logic [1:0] {IDLE, DUMP, WAIT_BLOCK} dump_state_t;
  function automatic logic [w-1:0] EndianSwitcher(input logic [w-1:0] a);
    logic [w-1:0] r;
    for (int i = 0; i < w_byte_size; i++)
      r[i*w_byte_width +: w_byte_width] = a[(w_byte_size-1-i)*w_byte_width +: w_byte_width];
    return r;
  endfunction
endpackage

// File: rtl/piso_buffer.sv
// piso_buffer: parallel-load, shift-by-WIDTH buffer presenting word 0
//   clk, rst (async active-low), i_load (parallel load, wins over shift),
//   i_shift (drop word 0), i_data (DEPTH words, word 0 in LSBs), o_data (word 0)
module piso_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_shift,
  input  logic [WIDTH*DEPTH-1:0] i_data,
  output logic [WIDTH-1:0]       o_data
);
  logic [WIDTH*DEPTH-1:0] r_buf;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_buf <= '0;
    else if (i_load) r_buf <= i_data;
    else if (i_shift) r_buf <= {{WIDTH{1'b0}}, r_buf[WIDTH*DEPTH-1:WIDTH]};
  assign o_data = r_buf[WIDTH-1:0];
endmodule

// File: rtl/dump_datapath.sv
// dump_datapath: serialises squeezed rate blocks into byte-swapped w-bit words with length tracking
//   clk, rst (async active-low)
//   block_valid_i/block_ready_o/rate_i : squeezed block from the permutation stage
//   operation_mode_i, output_size_i    : job mode and length in bits, latched on job start
//   more_o                             : job active, keep squeezing
//   data_o/valid_o/ready_i/last_o      : output word stream
//   done_o                             : one-cycle pulse after a job completes
module dump_datapath
  import keccak_pkg::*;
#(
  parameter int DEPTH = DUMP_DEPTH_SHAKE128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     block_valid_i,
  output logic                     block_ready_o,
  input  logic [RATE_SHAKE128-1:0] rate_i,
  input  logic [1:0]               operation_mode_i,
  input  logic [31:0]              output_size_i,
  output logic                     more_o,
  output logic [w-1:0]             data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     last_o,
  output logic                     done_o
);
  dump_state_t r_state, w_next;
  logic [4:0]   r_cnt;
  logic [31:0]  r_rem;
  logic [1:0]   r_mode;
  logic         r_done;
  logic [w-1:0] w_word, w_swap, w_masked;
  logic [1:0]   w_mode;
  logic [4:0]   w_cnt_init;
  logic         w_idle, w_xfer, w_final, w_accept;
  piso_buffer #(.WIDTH(w), .DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst(rst), .i_load(w_accept), .i_shift(w_xfer && !w_accept),
    .i_data(rate_i), .o_data(w_word)
  );
  assign w_idle     = r_state == IDLE;
  assign w_xfer     = valid_o && ready_i;
  assign w_final    = w_xfer && r_cnt == 5'd0 && !last_o;
  assign w_accept   = block_valid_i && block_ready_o;
  assign w_mode     = w_idle ? operation_mode_i : r_mode;
  assign w_cnt_init = w_mode == SHAKE256_MODE_VEC ? 5'(DUMP_DEPTH_SHAKE256 - 1) : 5'(DUMP_DEPTH_SHAKE128 - 1);
  assign w_swap     = EndianSwitcher(w_word);
  // In the final partial word only the first remaining/8 bytes carry output.
  for (genvar k = 0; k < w_byte_size; k++) begin : g_mask
    assign w_masked[k*w_byte_width +: w_byte_width] =
      (r_rem >= 32'(w) || 3'(k) < r_rem[5:3]) ? w_swap[k*w_byte_width +: w_byte_width] : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = (w_accept && output_size_i != 32'd0) ? DUMP : IDLE;
      DUMP:       w_next = (w_xfer && last_o) ? IDLE : w_final ? (w_accept ? DUMP : WAIT_BLOCK) : DUMP;
      WAIT_BLOCK: w_next = w_accept ? DUMP : WAIT_BLOCK;
      default:    w_next = IDLE;
    endcase
  end
  always_comb begin
    valid_o       = r_state == DUMP;
    last_o        = valid_o && r_rem <= 32'(w);
    data_o        = valid_o ? w_masked : '0;
    more_o        = !w_idle;
    done_o        = r_done;
    // Gated by rst so every output reads 0 while reset is held.
    block_ready_o = rst && (w_idle || r_state == WAIT_BLOCK || w_final);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_mode <= '0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_accept ? w_cnt_init : w_xfer ? r_cnt - 5'd1 : r_cnt;
      r_rem  <= (w_accept && w_idle) ? output_size_i :
                w_xfer ? (r_rem > 32'(w) ? r_rem - 32'(w) : 32'd0) : r_rem;
      r_mode <= (w_accept && w_idle) ? operation_mode_i : r_mode;
      r_done <= (w_accept && w_idle && output_size_i == 32'd0) || (w_xfer && last_o);
    end
endmodule

// File: tb/tb_dump_datapath.sv
// tb_dump_datapath: directed self-checking bench for dump_datapath
module tb_dump_datapath;
  import keccak_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic block_valid_i = 1'b0;
  logic block_ready_o;
  logic [RATE_SHAKE128-1:0] rate_i = '0;
  logic [1:0] operation_mode_i = '0;
  logic [31:0] output_size_i = '0;
  logic more_o;
  logic [63:0] data_o;
  logic valid_o;
  logic ready_i = 1'b0;
  logic last_o;
  logic done_o;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  dump_datapath dut (
    .clk(clk), .rst(rst), .block_valid_i(block_valid_i), .block_ready_o(block_ready_o),
    .rate_i(rate_i), .operation_mode_i(operation_mode_i), .output_size_i(output_size_i),
    .more_o(more_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .last_o(last_o), .done_o(done_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] mkword(input int tag, input int i);
    return {8'(tag), 8'(i), 8'h5A, 8'hC3, 8'(i * 3 + 1), 8'h96, 8'(tag) ^ 8'hFF, 8'(i) + 8'h40};
  endfunction
  function automatic logic [63:0] exp_word(input int tag, input int i, input int rem);
    logic [63:0] raw, sw, mask;
    raw = mkword(tag, i);
    sw = {<<8{raw}};
    mask = rem >= 64 ? '1 : (64'd1 << rem) - 64'd1;
    return sw & mask;
  endfunction
  task automatic present(input int tag);
    for (int i = 0; i < 21; i++) rate_i[64*i +: 64] = mkword(tag, i);
    block_valid_i = 1'b1;
  endtask
  task automatic start_job(input logic [1:0] mode, input int size, input int tag);
    operation_mode_i = mode;
    output_size_i = 32'(size);
    present(tag);
    #1;
    check("start_ready", block_ready_o, 1);
    check("start_more", more_o, 0);
    tick();
    block_valid_i = 1'b0;
  endtask
  task automatic take_word(input string tag, input logic [63:0] exp, input bit exp_last, input int stall);
    ready_i = 1'b0;
    for (int s = 0; s < stall; s++) begin
      #1;
      check({tag, "_stall_data"}, data_o, exp);
      check({tag, "_stall_last"}, last_o, exp_last);
      tick();
    end
    ready_i = 1'b1;
    #1;
    check({tag, "_valid"}, valid_o, 1);
    check({tag, "_data"}, data_o, exp);
    check({tag, "_last"}, last_o, exp_last);
    tick();
  endtask
  task automatic finish_job(input string tag);
    #1;
    check({tag, "_done"}, done_o, 1);
    check({tag, "_more_off"}, more_o, 0);
    check({tag, "_valid_off"}, valid_o, 0);
    tick();
    #1;
    check({tag, "_done_once"}, done_o, 0);
  endtask
  initial begin
    tick();
    #1;
    check("rst_ready", block_ready_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_more", more_o, 0);
    check("rst_done", done_o, 0);
    check("rst_last", last_o, 0);
    rst = 1'b1;
    tick();
    // SHAKE128, 256 bits: four full words from one block
    start_job(SHAKE128_MODE_VEC, 256, 1);
    #1;
    check("s1_busy_ready", block_ready_o, 0);
    check("s1_more", more_o, 1);
    for (int i = 0; i < 4; i++) take_word("s1", exp_word(1, i, 256 - 64 * i), i == 3, 0);
    finish_job("s1");
    // SHAKE256, 2000 bits: 17 words, wait for a second block, 15 words with a 2-byte tail
    start_job(SHAKE256_MODE_VEC, 2000, 2);
    for (int i = 0; i < 17; i++) take_word("s2a", exp_word(2, i, 2000 - 64 * i), 0, 0);
    for (int c = 0; c < 2; c++) begin
      #1;
      check("s2_wait_valid", valid_o, 0);
      check("s2_wait_ready", block_ready_o, 1);
      check("s2_wait_more", more_o, 1);
      tick();
    end
    present(3);
    tick();
    block_valid_i = 1'b0;
    for (int i = 0; i < 15; i++) take_word("s2b", exp_word(3, i, 912 - 64 * i), i == 14, 0);
    finish_job("s2");
    // Back-to-back: next block offered during the final word of the first
    start_job(SHAKE256_MODE_VEC, 1216, 4);
    for (int i = 0; i < 16; i++) take_word("s3a", exp_word(4, i, 1216 - 64 * i), 0, 0);
    present(5);
    ready_i = 1'b1;
    #1;
    check("s3_final_ready", block_ready_o, 1);
    check("s3_final_data", data_o, exp_word(4, 16, 192));
    tick();
    block_valid_i = 1'b0;
    take_word("s3b", exp_word(5, 0, 128), 0, 0);
    take_word("s3b", exp_word(5, 1, 64), 1, 0);
    finish_job("s3");
    // Backpressure with ready 1,0,0,1; undefined mode behaves as SHAKE128; 7-byte tail
    start_job(2'b00, 184, 6);
    take_word("s4", exp_word(6, 0, 184), 0, 0);
    take_word("s4", exp_word(6, 1, 120), 0, 2);
    take_word("s4", exp_word(6, 2, 56), 1, 1);
    finish_job("s4");
    // Zero-length job
    start_job(SHAKE128_MODE_VEC, 0, 7);
    #1;
    check("s5_valid", valid_o, 0);
    finish_job("s5");
    // Reset mid-dump after 3 words, then a clean job
    start_job(SHAKE128_MODE_VEC, 1344, 8);
    for (int i = 0; i < 3; i++) take_word("s6", exp_word(8, i, 1344 - 64 * i), 0, 0);
    rst = 1'b0;
    #1;
    check("s6_rst_valid", valid_o, 0);
    check("s6_rst_data", data_o, 0);
    check("s6_rst_more", more_o, 0);
    check("s6_rst_ready", block_ready_o, 0);
    check("s6_rst_last", last_o, 0);
    check("s6_rst_done", done_o, 0);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("s6_no_done", done_o, 0);
    end
    start_job(SHAKE128_MODE_VEC, 128, 9);
    take_word("s7", exp_word(9, 0, 128), 0, 0);
    take_word("s7", exp_word(9, 1, 64), 1, 0);
    finish_job("s7");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dump_datapath.md
Name: dump_datapath

Overview:
- Output stage of the SHAKE core; sits directly downstream of the permutation stage.
- Captures each squeezed rate block in parallel and serialises it as w-bit little-endian words on a valid/ready output port.
- Tracks the requested output length per job, zeroes unused bytes in the final word, and tells the permutation stage whether further squeezes are needed.

Parameters:
- w, 64, output word width in bits; taken from keccak_pkg.
- DEPTH, RATE_SHAKE128/w (21), buffer depth in words; sized for the largest rate.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- block_valid_i  in  1  squeezed block available from the permutation stage
- block_ready_o  out  1  stage accepts the block this cycle
- rate_i  in  RATE_SHAKE128  squeezed rate bits; word i is bits [64i+63:64i]
- operation_mode_i  in  2  mode; latched on job start
- output_size_i  in  32  requested output length in bits, multiple of 8; latched on job start
- more_o  out  1  job active; permutation stage keeps squeezing while high
- data_o  out  w  output word
- valid_o  out  1  data_o valid
- ready_i  in  1  consumer accepts data_o
- last_o  out  1  data_o is the final word of the job
- done_o  out  1  one-cycle pulse when a job completes

Behaviour:
- Reset values, asynchronous:
  - State is IDLE.
  - Buffer, counters, latched mode and latched size are 0.
  - All outputs are 0.
- Reset mid-job abandons the job and emits no done_o.
- Transfer: a word moves when valid_o && ready_i. With ready_i low, data_o and last_o hold stable.
- Block handshake: a block is accepted when block_valid_i && block_ready_o.
- Block word count is 17 for SHAKE256_MODE_VEC and 21 for SHAKE128_MODE_VEC or any other value.
- FSM states: IDLE, DUMP, WAIT_BLOCK.
- IDLE:
  - block_ready_o = 1.
  - On accept: latch mode and size, load rate_i into the buffer, load the word counter with count-1.
  - If output_size_i == 0: pulse done_o next cycle and stay in IDLE; no words are emitted.
  - Otherwise go to DUMP.
- DUMP:
  - valid_o = 1. data_o = EndianSwitcher(buffer word 0).
  - If remaining < 64, bytes at index >= remaining/8 of the output word are forced to 0.
  - last_o = (remaining <= 64).
  - On each transfer: shift the buffer by w, decrement the word counter, and set remaining = remaining - 64, saturating at 0.
  - Transfer with last_o: done_o pulses next cycle; go to IDLE. Unconsumed block words are discarded.
  - Transfer of the block's final word without last_o, same cycle: block_ready_o = 1.
    - If block_valid_i is also high: reload the buffer and stay in DUMP; no bubble.
    - Otherwise go to WAIT_BLOCK.
- WAIT_BLOCK:
  - block_ready_o = 1, valid_o = 0.
  - On accept: reload the buffer and word counter; mode and size are not re-latched. Go to DUMP.
- more_o = (state != IDLE).
- Latency: from block accept to the first valid_o is one cycle.
- Word counter is 5 bits. Remaining counter is 32 bits.

Decomposition:
- keccak_pkg, already present, holds:
  - w, w_byte_width and w_byte_size
  - RATE_SHAKE128 and RATE_SHAKE256
  - SHAKE128_MODE_VEC and SHAKE256_MODE_VEC
  - EndianSwitcher
- Add DUMP_DEPTH_SHAKE128 = 21 and DUMP_DEPTH_SHAKE256 = 17 to keccak_pkg.
- Sub-module piso_buffer (WIDTH, DEPTH):
  - Parallel load and shift-by-WIDTH; output is word 0.
  - Counterpart of sipo_buffer.
- FSM, counters and masking stay in dump_datapath.

Test Plan:
- SHAKE128, size 256, one block, ready_i = 1 → 4 consecutive valid_o words, each the byte-swapped rate word i. last_o on word 4, done_o the following cycle, more_o low afterwards.
- SHAKE256, size 2000:
  - Block A → 17 words, then WAIT_BLOCK with block_ready_o = 1.
  - Block B → 15 words. The last has bytes 0..1 from the swapped word and bytes 2..7 equal to 0, with last_o set.
- Back-to-back blocks: block_valid_i held high during the final word of block A → the first word of B appears on the next cycle. No valid_o gap; word count is continuous.
- Backpressure: ready_i toggled 1,0,0,1 → data_o and last_o stable while stalled. Word order unchanged; total word count matches the size.
- Size 0 → block accepted, no valid_o, done_o pulses once, more_o stays 0.
- rst asserted mid-DUMP, after 3 of 21 words → all outputs 0 immediately. The next job starts clean from IDLE, and done_o is never raised for the aborted job.
